// File: rtl/dsp_pkg.sv
// Shared fixed-point DSP definitions: default widths, unity coefficient and
// the FSM encoding used by the multicycle filter blocks.
package dsp_pkg;

  // Default sample/coefficient/accumulator width (signed two's complement)
  localparam int BIT_NO_DEF = 32;
  // Default coefficient scale exponent; unity gain is 1 << (CK - 1)
  localparam int CK_DEF = 11;
  // Unity coefficient for the default scale
  localparam int UNITY_COEF = 1 << (CK_DEF - 1);

  // Filter control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Unity coefficient for an arbitrary scale exponent
  function automatic int unity_coef(input int ck);
    return 1 << (ck - 1);
  endfunction

endpackage

// File: rtl/iir_inverse_fir_if.sv
// Sample stream in/out (valid/ready) plus the coefficient write port of the
// inverse-IIR FIR equalizer.
interface iir_inverse_fir_if
  import dsp_pkg::*;
#(
  parameter int BIT_NO = BIT_NO_DEF
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic signed [BIT_NO-1:0] in_data;

  logic                     out_valid;
  logic                     out_ready;
  logic signed [BIT_NO-1:0] out_data;

  logic                     coef_we;
  logic [1:0]               coef_addr;
  logic signed [BIT_NO-1:0] coef_wdata;
  logic                     coef_ack;

  // Upstream/downstream side that drives samples, back-pressure and writes
  modport master (
    output in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    input  in_ready, out_valid, out_data, coef_ack
  );

  // Filter side
  modport slave (
    input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    output in_ready, out_valid, out_data, coef_ack
  );

endinterface

// File: rtl/fx_mul_shift.sv
// Signed fixed-point multiply: full-width product, arithmetic shift right by
// CK-1 to remove the coefficient scale, truncated back to BIT_NO bits.
module fx_mul_shift
  import dsp_pkg::*;
#(
  parameter int BIT_NO = BIT_NO_DEF,
  parameter int CK     = CK_DEF
) (
  input  logic signed [BIT_NO-1:0] a,
  input  logic signed [BIT_NO-1:0] b,
  output logic signed [BIT_NO-1:0] y
);

  logic signed [2*BIT_NO-1:0] prod;

  // Exact product, then rescale and keep the low BIT_NO bits (wraps)
  always_comb begin
    prod = (2*BIT_NO)'(a) * (2*BIT_NO)'(b);
    y    = BIT_NO'(prod >>> (CK - 1));
  end

endmodule

// File: rtl/iir_inverse_fir.sv
// Multicycle 3-tap FIR whose zeros cancel the poles of the upstream IIR
// stage. One shared multiplier walks the taps; a fourth MAC-state cycle
// moves the finished sum into the output register.
module iir_inverse_fir
  import dsp_pkg::*;
#(
  parameter int BIT_NO = BIT_NO_DEF,
  parameter int CK     = CK_DEF
) (
  input logic              clk,
  input logic              reset,
  iir_inverse_fir_if.slave bus
);

  localparam int NTAPS = 3;
  localparam logic signed [BIT_NO-1:0] UNITY = BIT_NO'(unity_coef(CK));
  // Tap index at which the accumulator is complete and gets published
  localparam logic [1:0] TAP_DONE = 2'd3;

  state_t                   state_q, state_d;
  logic [1:0]               tap_q, tap_d;
  logic signed [BIT_NO-1:0] acc_q, acc_d;
  logic signed [BIT_NO-1:0] s_q [NTAPS];
  logic signed [BIT_NO-1:0] s_d [NTAPS];
  logic signed [BIT_NO-1:0] h_q [NTAPS];
  logic signed [BIT_NO-1:0] h_d [NTAPS];
  logic signed [BIT_NO-1:0] out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     in_ready_q, in_ready_d;
  logic                     coef_ack_q, coef_ack_d;

  logic [NTAPS-1:0]         coef_hit;
  logic signed [BIT_NO-1:0] s_sel;
  logic signed [BIT_NO-1:0] h_sel;
  logic signed [BIT_NO-1:0] prod_scaled;

  // Coefficient writes land only while idle; address 3 matches no tap
  generate
    for (genvar gi = 0; gi < NTAPS; gi++) begin : g_coef_hit
      assign coef_hit[gi] = in_ready_q && (state_q == ST_IDLE) && bus.coef_we &&
                            (bus.coef_addr == 2'(gi));
    end
  endgenerate

  // Select the sample/coefficient pair for the current tap
  always_comb begin
    s_sel = '0;
    h_sel = '0;
    case (tap_q)
      2'd0: begin s_sel = s_q[0]; h_sel = h_q[0]; end
      2'd1: begin s_sel = s_q[1]; h_sel = h_q[1]; end
      2'd2: begin s_sel = s_q[2]; h_sel = h_q[2]; end
      default: begin s_sel = '0; h_sel = '0; end
    endcase
  end

  fx_mul_shift #(
    .BIT_NO (BIT_NO),
    .CK     (CK)
  ) u_mul (
    .a (s_sel),
    .b (h_sel),
    .y (prod_scaled)
  );

  // Next-state logic: sample intake, tap-serial MAC, output hold
  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    coef_ack_d  = |coef_hit;
    for (int i = 0; i < NTAPS; i++) begin
      s_d[i] = s_q[i];
      h_d[i] = coef_hit[i] ? bus.coef_wdata : h_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (in_ready_q && bus.in_valid) begin
          s_d[0]  = bus.in_data;
          s_d[1]  = s_q[0];
          s_d[2]  = s_q[1];
          acc_d   = '0;
          tap_d   = 2'd0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        if (tap_q == TAP_DONE) begin
          out_data_d  = acc_q;
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
        end else begin
          acc_d = acc_q + prod_scaled;
          tap_d = tap_q + 2'd1;
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

  // State registers; reset restores passthrough coefficients and drops work
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      tap_q       <= 2'd0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      coef_ack_q  <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        s_q[i] <= '0;
        h_q[i] <= (i == 0) ? UNITY : '0;
      end
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      coef_ack_q  <= coef_ack_d;
      for (int i = 0; i < NTAPS; i++) begin
        s_q[i] <= s_d[i];
        h_q[i] <= h_d[i];
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.coef_ack  = coef_ack_q;

endmodule
